// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main control: sequences fetch, decode, execute,
// memory and writeback over a shared ALU and a single memory port.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  ALUOp,
    output logic [1:0]  pc_source,
    output logic        illegal,
    output logic        instr_done,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        WB_R      = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        WB_LOAD   = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t cur;

    logic is_r;
    logic is_ldur;
    logic is_stur;
    logic is_cbz;
    logic is_b;

    assign is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_ORR);
    assign is_ldur = (opcode == OP_LDUR);
    assign is_stur = (opcode == OP_STUR);
    assign is_cbz  = (opcode[10:3] == 8'b10110100);
    assign is_b    = (opcode[10:5] == 6'b000101);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= state_t'(RESET_STATE);
        end else begin
            case (cur)
                FETCH: begin
                    if (mem_ready) cur <= DECODE;
                end
                DECODE: begin
                    unique case (1'b1)
                        is_r:              cur <= EXEC_R;
                        is_ldur || is_stur: cur <= MEM_ADDR;
                        is_cbz:            cur <= BRANCH;
                        is_b:              cur <= JUMP;
                        default:           cur <= FETCH;
                    endcase
                end
                EXEC_R:   cur <= WB_R;
                WB_R:     cur <= FETCH;
                MEM_ADDR: begin
                    unique case (1'b1)
                        is_ldur: cur <= MEM_READ;
                        is_stur: cur <= MEM_WRITE;
                        default: cur <= FETCH;
                    endcase
                end
                MEM_READ: begin
                    if (mem_ready) cur <= WB_LOAD;
                end
                WB_LOAD:  cur <= FETCH;
                MEM_WRITE: begin
                    if (mem_ready) cur <= FETCH;
                end
                BRANCH:   cur <= FETCH;
                JUMP:     cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    // Reset blanks every output so an abandoned instruction has no side effects.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg2loc    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALUOp      = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        state      = 4'd0;
        if (!reset) begin
            state = cur;
            case (cur)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    reg2loc   = is_stur || is_cbz;
                    if (!(is_r || is_ldur || is_stur || is_cbz || is_b)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    ALUOp     = 2'b10;
                end
                WB_R: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    reg2loc   = is_stur;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                end
                WB_LOAD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    reg2loc    = 1'b1;
                    instr_done = mem_ready;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    ALUOp      = 2'b01;
                    reg2loc    = 1'b1;
                    pc_source  = 2'b01;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle traces
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        mem_to_reg, reg2loc, alu_src_a, illegal, instr_done;
    logic [1:0]  alu_src_b, ALUOp, pc_source;
    logic [3:0]  state;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .pc_source(pc_source),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    typedef struct {
        logic [10:0] opc;
        logic        mr;
        logic        z;
        logic [19:0] exp;
    } step_t;

    step_t         plan[$];
    logic [19:0]   exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc_no = 0;
    logic [10:0]   rops[4] = '{11'b10001011000, 11'b11001011000,
                               11'b10001010000, 11'b10101010000};

    // Instruction class from the opcode patterns of the ISA subset.
    function automatic int classify(input logic [10:0] o);
        if (o == 11'b10001011000 || o == 11'b11001011000 ||
            o == 11'b10001010000 || o == 11'b10101010000) return K_R;
        if (o == 11'b11111000010) return K_LD;
        if (o == 11'b11111000000) return K_ST;
        if (o[10:3] == 8'b10110100) return K_CBZ;
        if (o[10:5] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    // ctl = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, reg2loc, alu_src_a}
    function automatic logic [19:0] mk(input logic [3:0] st, input logic [7:0] ctl,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] pcs, input logic ill,
                                       input logic done);
        return {st, ctl, asb, aop, pcs, ill, done};
    endfunction

    task automatic add(input logic [10:0] o, input logic mr, input logic z,
                       input logic [19:0] e);
        step_t s;
        s.opc = o; s.mr = mr; s.z = z; s.exp = e;
        plan.push_back(s);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expected cycle-by-cycle trace of one whole instruction.
    task automatic build(input logic [10:0] o, input int fst, input int dst,
                         input logic z);
        int k;
        k = classify(o);
        for (int i = 0; i < fst; i++)
            add(11'($urandom), 1'b0, rb(), mk(4'd0, 8'b00100000, 2'b01, 2'b00, 2'b00, 0, 0));
        add(11'($urandom), 1'b1, rb(), mk(4'd0, 8'b11100000, 2'b01, 2'b00, 2'b00, 0, 0));
        add(o, rb(), rb(), mk(4'd1, {6'b0, (k == K_ST || k == K_CBZ), 1'b0},
                              2'b11, 2'b00, 2'b00, k == K_ILL, k == K_ILL));
        case (k)
            K_R: begin
                add(o, rb(), rb(), mk(4'd2, 8'b00000001, 2'b00, 2'b10, 2'b00, 0, 0));
                add(o, rb(), rb(), mk(4'd3, 8'b00001000, 2'b00, 2'b00, 2'b00, 0, 1));
            end
            K_LD: begin
                add(o, rb(), rb(), mk(4'd4, 8'b00000001, 2'b10, 2'b00, 2'b00, 0, 0));
                for (int i = 0; i < dst; i++)
                    add(o, 1'b0, rb(), mk(4'd5, 8'b00100000, 2'b00, 2'b00, 2'b00, 0, 0));
                add(o, 1'b1, rb(), mk(4'd5, 8'b00100000, 2'b00, 2'b00, 2'b00, 0, 0));
                add(o, rb(), rb(), mk(4'd6, 8'b00001100, 2'b00, 2'b00, 2'b00, 0, 1));
            end
            K_ST: begin
                add(o, rb(), rb(), mk(4'd4, 8'b00000011, 2'b10, 2'b00, 2'b00, 0, 0));
                for (int i = 0; i < dst; i++)
                    add(o, 1'b0, rb(), mk(4'd7, 8'b00010010, 2'b00, 2'b00, 2'b00, 0, 0));
                add(o, 1'b1, rb(), mk(4'd7, 8'b00010010, 2'b00, 2'b00, 2'b00, 0, 1));
            end
            K_CBZ:
                add(o, rb(), z, mk(4'd8, {z, 5'b0, 2'b11}, 2'b00, 2'b01, 2'b01, 0, 1));
            K_B:
                add(o, rb(), rb(), mk(4'd9, 8'b10000000, 2'b00, 2'b00, 2'b10, 0, 1));
            default: begin
            end
        endcase
    endtask

    task automatic cyc(input logic rst, input step_t s);
        reset = rst;
        opcode = s.opc;
        mem_ready = s.mr;
        zero = s.z;
        exp_q.push_back(rst ? 20'h0 : s.exp);
        @(posedge clk);
        #1;
    endtask

    // Replays the plan; abort >= 0 replaces that step with a reset cycle.
    task automatic play(input int abort);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort) begin
                cyc(1'b1, plan[i]);
                break;
            end
            cyc(1'b0, plan[i]);
        end
        plan.delete();
    endtask

    always @(negedge clk) begin
        logic [19:0] got, e;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {state, pc_write, ir_write, mem_read, mem_write, reg_write,
                   mem_to_reg, reg2loc, alu_src_a, alu_src_b, ALUOp,
                   pc_source, illegal, instr_done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle%0d outputs: got=%05h expected=%05h (reset=%0b opcode=%011b)",
                         cyc_no, got, e, reset, opcode);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t s;
        int k, ab;
        logic [10:0] o;
        s.opc = '0; s.mr = 1'b1; s.z = 1'b0; s.exp = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, s);
        cyc(1'b1, s);

        build(11'b10001011000, 0, 0, 1'b0); play(-1);
        build(11'b11111000010, 0, 3, 1'b0); play(-1);
        build(11'b11111000000, 0, 0, 1'b0); play(-1);
        build(11'b10110100101, 1, 0, 1'b1); play(-1);
        build(11'b10110100000, 0, 0, 1'b0); play(-1);
        build(11'b00010111011, 2, 0, 1'b0); play(-1);
        build(11'b11111111111, 0, 0, 1'b0); play(-1);
        build(11'b11111000000, 0, 3, 1'b0); play(5);
        build(11'b10101010000, 0, 0, 1'b0); play(-1);

        for (int n = 0; n < 120; n++) begin
            k = $urandom_range(0, 5);
            case (k)
                K_R:   o = rops[$urandom_range(0, 3)];
                K_LD:  o = 11'b11111000010;
                K_ST:  o = 11'b11111000000;
                K_CBZ: o = {8'b10110100, 3'($urandom)};
                K_B:   o = {6'b000101, 5'($urandom)};
                default: begin
                    o = 11'($urandom);
                    while (classify(o) != K_ILL) o = 11'($urandom);
                end
            endcase
            build(o, $urandom_range(0, 3), $urandom_range(0, 3), rb());
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, plan.size() - 1) : -1;
            play(ab);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
